// File: rtl/pipe_pkg.sv
// Shared definitions for the 5-stage 16-bit core pipeline control.
package pipe_pkg;

  localparam int REG_W  = 3;
  localparam int DATA_W = 16;

  localparam logic [DATA_W-1:0] NOP_INSTR = '0;

  typedef enum logic [2:0] {
    ST_RST_FLUSH  = 3'd0,
    ST_RUN        = 3'd1,
    ST_LOAD_STALL = 3'd2,
    ST_REFILL     = 3'd3,
    ST_HALT       = 3'd4
  } pipe_state_e;

endpackage

// File: rtl/sat_counter.sv
// Performance counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (inc && (r_count != {CNT_W{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: PC/stage enables, flushes and next-PC select from
// redirect, load-use, data-memory stall and HALT, plus stall/flush counters.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int REFILL_CYC = 2,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wb_redirect,
  input  logic             wb_halt,
  input  logic             dmem_stall,
  input  logic             ex_mem_read,
  input  logic             ex_rd_we,
  input  logic [REG_W-1:0] ex_rd,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_rs_use,
  input  logic             id_rt_use,
  output logic             pc_we,
  output logic             pc_sel,
  output logic             if_id_we,
  output logic             id_ex_we,
  output logic             ex_mem_we,
  output logic             mem_wb_we,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output pipe_state_e      dbg_state
);

  localparam logic [2:0] REFILL_INIT = 3'(REFILL_CYC);

  pipe_state_e r_state;
  logic [2:0]  r_refill_cnt;
  logic        r_halted;

  pipe_state_e w_next_state;
  logic [2:0]  w_next_cnt;
  logic        w_load_use;
  logic        w_redirect_acc;
  logic        w_stall_inc;

  assign w_load_use = ex_mem_read & ex_rd_we &
                      ((id_rs_use & (id_rs == ex_rd)) | (id_rt_use & (id_rt == ex_rd)));

  always_comb begin
    w_next_state   = r_state;
    w_next_cnt     = r_refill_cnt;
    w_redirect_acc = 1'b0;
    pc_we          = 1'b0;
    pc_sel         = 1'b0;
    if_id_we       = 1'b0;
    id_ex_we       = 1'b0;
    ex_mem_we      = 1'b0;
    mem_wb_we      = 1'b0;
    if_id_flush    = 1'b0;
    id_ex_flush    = 1'b0;
    ex_mem_flush   = 1'b0;
    case (r_state)
      ST_RST_FLUSH: begin
        {if_id_we, id_ex_we, ex_mem_we, mem_wb_we} = 4'b1111;
        {if_id_flush, id_ex_flush, ex_mem_flush}   = 3'b111;
        w_next_state = ST_RUN;
      end
      ST_HALT: begin
        w_next_state = ST_HALT;
      end
      default: begin
        if (wb_halt) begin
          {if_id_flush, id_ex_flush, ex_mem_flush} = 3'b111;
          w_next_state = ST_HALT;
        end else if (dmem_stall) begin
          // Full freeze: state and refill count hold so pending events re-evaluate later.
          w_next_state = r_state;
        end else if (wb_redirect) begin
          pc_we  = 1'b1;
          pc_sel = 1'b1;
          {if_id_we, id_ex_we, ex_mem_we, mem_wb_we} = 4'b1111;
          {if_id_flush, id_ex_flush, ex_mem_flush}   = 3'b111;
          w_redirect_acc = 1'b1;
          w_next_state   = (REFILL_CYC > 0) ? ST_REFILL : ST_RUN;
          w_next_cnt     = REFILL_INIT;
        end else if (r_state == ST_REFILL) begin
          pc_we       = 1'b1;
          {if_id_we, id_ex_we, ex_mem_we, mem_wb_we} = 4'b1111;
          if_id_flush = 1'b1;
          if (r_refill_cnt <= 3'd1) begin
            w_next_state = ST_RUN;
          end else begin
            w_next_cnt = r_refill_cnt - 3'd1;
          end
        end else if ((r_state == ST_RUN) && w_load_use) begin
          // LOAD_STALL gives exactly one bubble, so load-use is only checked from RUN.
          {id_ex_we, ex_mem_we, mem_wb_we} = 3'b111;
          id_ex_flush  = 1'b1;
          w_next_state = ST_LOAD_STALL;
        end else begin
          pc_we = 1'b1;
          {if_id_we, id_ex_we, ex_mem_we, mem_wb_we} = 4'b1111;
          w_next_state = ST_RUN;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_RST_FLUSH;
      r_refill_cnt <= '0;
      r_halted     <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_refill_cnt <= w_next_cnt;
      if (w_next_state == ST_HALT) begin
        r_halted <= 1'b1;
      end
    end
  end

  assign w_stall_inc = (r_state != ST_RST_FLUSH) && (r_state != ST_HALT) && !pc_we;
  assign halted      = r_halted;
  assign dbg_state   = r_state;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_stall_inc),
    .count (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_redirect_acc),
    .count (flush_cnt)
  );

endmodule
